decode_stage: RTL and testbench

- RV32I instruction-decode stage.
- Accepts one fetched instruction per handshake and reads rs1/rs2 from an internal 32x32 register file.
- Generates the sign-extended immediate for the instruction format.
- Presents idata/rv1/rv2/imm/pc to the execute stage (I_type, R_type, etc.) through a one-entry ID/EX pipeline register with valid/ready flow control.
- The register-file write port is driven by the writeback stage.

---
 rtl/decode_stage_pkg.sv | 30 +++
 rtl/decode_stage_if.sv | 15 +
 rtl/decode_stage_regfile_2r1w.sv | 29 ++
 rtl/decode_stage.sv | 72 +++++++
 tb/tb_decode_stage.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: datapath bounds, RV32I opcodes and immediate-format classification.
package decode_stage_pkg;
   localparam int MSB   = 31;
   localparam int LSB   = 0;
   localparam int XLEN  = MSB - LSB + 1;
   localparam int NREGS = 32;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] FENCE  = 7'b0001111;
   typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_BAD} imm_fmt_e;
   function automatic imm_fmt_e fmt_of(input logic [6:0] op);
      case (op)
         OP_IMM, LOAD, JALR, SYSTEM: return FMT_I;
         STORE:                      return FMT_S;
         BRANCH:                     return FMT_B;
         LUI, AUIPC:                 return FMT_U;
         JAL:                        return FMT_J;
         OP, FENCE:                  return FMT_R;
         default:                    return FMT_BAD;
      endcase
   endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, writeback and execute-side signals of the decode stage.
interface decode_stage_if;
   import decode_stage_pkg::*;
   logic            if_valid, if_ready, flush;
   logic [XLEN-1:0] if_instr, if_pc;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_valid, ex_ready, illegal;
   logic [XLEN-1:0] idata, rv1, rv2, imm, pc;
   modport master (output if_valid, if_instr, if_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
                   input  if_ready, ex_valid, idata, rv1, rv2, imm, pc, illegal);
   modport slave  (input  if_valid, if_instr, if_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
                   output if_ready, ex_valid, idata, rv1, rv2, imm, pc, illegal);
endinterface

// File: rtl/decode_stage_regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two combinational reads, one synchronous write, x0 reads zero.
// With DECODE_BYPASS_EN a same-cycle write is forwarded to the read ports.
module regfile_2r1w
   import decode_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_we,
   input  logic [4:0]      i_wa,
   input  logic [XLEN-1:0] i_wd,
   input  logic [4:0]      i_ra1,
   input  logic [4:0]      i_ra2,
   output logic [XLEN-1:0] o_rd1,
   output logic [XLEN-1:0] o_rd2
);
   logic [XLEN-1:0] r_mem [NREGS];
   logic            w_wr;
   assign w_wr = i_we && (i_wa != '0);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_mem <= '{default: '0};
      else if (w_wr) r_mem[i_wa] <= i_wd;
`ifdef DECODE_BYPASS_EN
   assign o_rd1 = (i_ra1 == '0) ? '0 : (w_wr && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
   assign o_rd2 = (i_ra2 == '0) ? '0 : (w_wr && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
`else
   assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
   assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register-file read, immediate generation and a one-entry ID/EX register.
// Optional write-through bypass into the captured operands: DECODE_BYPASS_EN.
module decode_stage
   import decode_stage_pkg::*;
(
   input logic           clk,
   input logic           reset_n,
   decode_stage_if.slave bus
);
   logic [XLEN-1:0] w_i, w_imm, w_rd1, w_rd2;
   logic            w_ready, w_load;
   imm_fmt_e        w_fmt;
   logic            r_valid, r_illegal;
   logic [XLEN-1:0] r_idata, r_rv1, r_rv2, r_imm, r_pc;
   assign w_i     = bus.if_instr;
   assign w_fmt   = fmt_of(w_i[6:0]);
   assign w_ready = !bus.flush && (!r_valid || bus.ex_ready);
   assign w_load  = bus.if_valid && w_ready;
   regfile_2r1w u_rf (
      .clk     (clk),
      .reset_n (reset_n),
      .i_we    (bus.wb_we),
      .i_wa    (bus.wb_rd),
      .i_wd    (bus.wb_data),
      .i_ra1   (w_i[19:15]),
      .i_ra2   (w_i[24:20]),
      .o_rd1   (w_rd1),
      .o_rd2   (w_rd2)
   );
   always_comb begin
      w_imm = '0;
      case (w_fmt)
         FMT_I:   w_imm = {{20{w_i[31]}}, w_i[31:20]};
         FMT_S:   w_imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
         FMT_B:   w_imm = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
         FMT_U:   w_imm = {w_i[31:12], 12'b0};
         FMT_J:   w_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
         default: w_imm = '0;
      endcase
   end
   // flush outranks load; a stalled entry keeps every output bit-stable
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_illegal <= 1'b0;
         r_idata   <= '0;
         r_rv1     <= '0;
         r_rv2     <= '0;
         r_imm     <= '0;
         r_pc      <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid   <= 1'b1;
         r_illegal <= (w_fmt == FMT_BAD);
         r_idata   <= w_i;
         r_rv1     <= w_rd1;
         r_rv2     <= w_rd2;
         r_imm     <= w_imm;
         r_pc      <= bus.if_pc;
      end else if (bus.ex_ready) begin
         r_valid <= 1'b0;
      end
   assign bus.if_ready = w_ready;
   assign bus.ex_valid = r_valid;
   assign bus.illegal  = r_illegal;
   assign bus.idata    = r_idata;
   assign bus.rv1      = r_rv1;
   assign bus.rv2      = r_rv2;
   assign bus.imm      = r_imm;
   assign bus.pc       = r_pc;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage with hand-computed expectations.
module tb_decode_stage;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   decode_stage_if bus();
   decode_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic offer(input logic [31:0] ins, input logic [31:0] a);
      bus.if_valid = 1'b1;
      bus.if_instr = ins;
      bus.if_pc    = a;
   endtask
   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      bus.wb_we   = 1'b1;
      bus.wb_rd   = rd;
      bus.wb_data = d;
   endtask
   initial begin
      bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.flush = 0;
      bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.ex_ready = 0;
      #12;
      chk("rst_valid", 32'(bus.ex_valid), 0);
      chk("rst_idata", bus.idata, 0);
      chk("rst_rv1", bus.rv1, 0);
      chk("rst_imm", bus.imm, 0);
      chk("rst_pc", bus.pc, 0);
      chk("rst_illegal", 32'(bus.illegal), 0);
      chk("rst_if_ready", 32'(bus.if_ready), 1);
      reset_n = 1'b1;
      wb(5, 32'h0000_0010);
      step();
      bus.wb_we = 0;
      bus.ex_ready = 1;
      offer(32'hFFD28313, 32'h100);
      step();
      bus.if_valid = 0;
      chk("addi_valid", 32'(bus.ex_valid), 1);
      chk("addi_rv1", bus.rv1, 32'h10);
      chk("addi_rv2", bus.rv2, 0);
      chk("addi_imm", bus.imm, 32'hFFFF_FFFD);
      chk("addi_illegal", 32'(bus.illegal), 0);
      chk("addi_idata", bus.idata, 32'hFFD28313);
      chk("addi_pc", bus.pc, 32'h100);
      step();
      chk("drain_valid", 32'(bus.ex_valid), 0);
      bus.ex_ready = 0;
      offer(32'h0020A423, 32'h200);
      step();
      chk("sw_valid", 32'(bus.ex_valid), 1);
      chk("sw_imm", bus.imm, 32'h8);
      offer(32'hFE0008E3, 32'h204);
      chk("stall_if_ready", 32'(bus.if_ready), 0);
      step();
      step();
      chk("stall_idata", bus.idata, 32'h0020A423);
      chk("stall_imm", bus.imm, 32'h8);
      chk("stall_pc", bus.pc, 32'h200);
      bus.ex_ready = 1;
      #1;
      chk("unstall_if_ready", 32'(bus.if_ready), 1);
      step();
      chk("beq_idata", bus.idata, 32'hFE0008E3);
      chk("beq_imm", bus.imm, 32'hFFFF_FFF0);
      chk("beq_pc", bus.pc, 32'h204);
      offer(32'h123450B7, 32'h208);
      step();
      chk("lui_valid", 32'(bus.ex_valid), 1);
      chk("lui_imm", bus.imm, 32'h1234_5000);
      bus.if_valid = 0;
      step();
      chk("lui_drain", 32'(bus.ex_valid), 0);
      wb(0, 32'hDEAD_BEEF);
      step();
      bus.wb_we = 0;
      offer(32'h00500093, 32'h20C);
      step();
      chk("x0_rv1", bus.rv1, 0);
      chk("x0_imm", bus.imm, 32'h5);
      offer(32'hFFFF_FFFF, 32'h210);
      step();
      chk("bad_valid", 32'(bus.ex_valid), 1);
      chk("bad_illegal", 32'(bus.illegal), 1);
      chk("bad_imm", bus.imm, 0);
      bus.if_valid = 0;
      wb(7, 32'h1111_1111);
      step();
      wb(7, 32'hA5A5_A5A5);
      offer(32'h00038413, 32'h214);
      step();
`ifdef DECODE_BYPASS_EN
      chk("bypass_rv1", bus.rv1, 32'hA5A5_A5A5);
`else
      chk("bypass_rv1", bus.rv1, 32'h1111_1111);
`endif
      bus.wb_we = 0;
      step();
      chk("x7_rv1", bus.rv1, 32'hA5A5_A5A5);
      bus.ex_ready = 0;
      offer(32'h00500093, 32'h300);
      step();
      chk("flush_pre_valid", 32'(bus.ex_valid), 1);
      offer(32'h123450B7, 32'h304);
      bus.flush = 1;
      #1;
      chk("flush_if_ready", 32'(bus.if_ready), 0);
      step();
      chk("flush_valid", 32'(bus.ex_valid), 0);
      bus.flush = 0;
      bus.if_valid = 0;
      step();
      chk("flush_no_accept", 32'(bus.ex_valid), 0);
      offer(32'hFFD28313, 32'h400);
      step();
      chk("pre_rst_valid", 32'(bus.ex_valid), 1);
      #3;
      reset_n = 0;
      #1;
      chk("mid_rst_valid", 32'(bus.ex_valid), 0);
      chk("mid_rst_idata", bus.idata, 0);
      chk("mid_rst_rv1", bus.rv1, 0);
      chk("mid_rst_imm", bus.imm, 0);
      chk("mid_rst_pc", bus.pc, 0);
      reset_n = 1;
      bus.ex_ready = 1;
      step();
      chk("rf_cleared_valid", 32'(bus.ex_valid), 1);
      chk("rf_cleared_rv1", bus.rv1, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
